// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and digit-vector helpers for the multi-digit counter.
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX    = 4'd9;
   // Widest counter the vector helpers cover; callers zero-extend into this width.
   localparam int         MAX_DIGITS = 16;

   function automatic logic is_bcd(input bcd_digit_t nibble);
      return nibble <= BCD_MAX;
   endfunction

   function automatic logic all_nines(input logic [4*MAX_DIGITS-1:0] v, input int n);
      for (int i = 0; i < MAX_DIGITS; i++)
         if (i < n && v[4*i +: 4] != BCD_MAX) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic all_zeros(input logic [4*MAX_DIGITS-1:0] v, input int n);
      for (int i = 0; i < MAX_DIGITS; i++)
         if (i < n && v[4*i +: 4] != 4'd0) return 1'b0;
      return 1'b1;
   endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One combinational BCD decade: next value plus a wrap flag that feeds the higher digit's enable.
module bcd_digit_step
   import bcd_pkg::*;
(
   input  bcd_digit_t digit,
   input  logic       step_en,
   input  logic       up,
   output bcd_digit_t next_digit,
   output logic       wrap
);

   always_comb begin
      // wrap is independent of step_en so the caller can AND it into the chain
      wrap       = up ? (digit == BCD_MAX) : (digit == 4'd0);
      next_digit = digit;
      if (step_en) begin
         if (wrap)    next_digit = up ? 4'd0 : BCD_MAX;
         else if (up) next_digit = digit + 4'd1;
         else         next_digit = digit - 4'd1;
      end
   end

endmodule

// File: rtl/bcd_multi_digit_counter.sv
// DIGITS-decade BCD up/down counter with validated parallel load, optional saturation,
// registered carry/borrow pulse and combinational terminal count.
module bcd_multi_digit_counter
   import bcd_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter bit SATURATE = 1'b0
) (
   input  logic                CLK,
   input  logic                CLR,
   input  logic                ENABLE,
   input  logic                LOAD,
   input  logic                UP,
   input  logic [4*DIGITS-1:0] D,
   output logic [4*DIGITS-1:0] Q,
   output logic                CO,
   output logic                TC,
   output logic                ERR
);

   logic [DIGITS-1:0]       step_en;
   logic [DIGITS-1:0]       wrap;
   logic [4*DIGITS-1:0]     q_next;
   logic [4*MAX_DIGITS-1:0] q_ext;
   logic                    load_ok;
   logic                    at_limit;

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      if (i == 0) begin : g_lsd
         assign step_en[i] = 1'b1;
      end else begin : g_chain
         assign step_en[i] = step_en[i-1] & wrap[i-1];
      end

      bcd_digit_step u_digit (
         .digit      (Q[4*i +: 4]),
         .step_en    (step_en[i]),
         .up         (UP),
         .next_digit (q_next[4*i +: 4]),
         .wrap       (wrap[i])
      );
   end

   // Whole counter sits at 9..9 (up) or 0..0 (down): the next count wraps or saturates.
   assign at_limit = step_en[DIGITS-1] & wrap[DIGITS-1];

   always_comb begin
      load_ok = 1'b1;
      for (int i = 0; i < DIGITS; i++)
         if (!is_bcd(D[4*i +: 4])) load_ok = 1'b0;
   end

   always_comb begin
      q_ext                 = '0;
      q_ext[4*DIGITS-1:0]   = Q;
   end

   assign TC = UP ? all_nines(q_ext, DIGITS) : all_zeros(q_ext, DIGITS);

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         Q   <= '0;
         CO  <= 1'b0;
         ERR <= 1'b0;
      end else if (!ENABLE) begin
         CO  <= 1'b0;
      end else if (LOAD) begin
         CO  <= 1'b0;
         if (load_ok) begin
            Q   <= D;
            ERR <= 1'b0;
         end else begin
            ERR <= 1'b1;
         end
      end else begin
         ERR <= 1'b0;
         if (SATURATE && at_limit) begin
            CO <= 1'b0;
         end else begin
            Q  <= q_next;
            CO <= at_limit;
         end
      end
   end

endmodule

// File: tb/tb_bcd_multi_digit_counter.sv
// Scoreboard bench: wrapping and saturating 3-digit counters share stimulus and are
// compared each cycle against an integer-valued reference model.
module tb_bcd_multi_digit_counter;

   localparam int DIGITS = 3;
   localparam int MAXV   = 999;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        enable = 1'b0;
   logic        load = 1'b0;
   logic        up = 1'b0;
   logic [11:0] d = '0;
   logic [11:0] q_w, q_s;
   logic        co_w, co_s, tc_w, tc_s, err_w, err_s;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int q[2];
      bit co[2];
      bit err[2];
   } exp_t;

   exp_t exp_q[$];

   // reference model state: index 0 = wrapping, 1 = saturating
   int mv[2];
   bit mco[2];
   bit merr[2];

   always #5 clk = ~clk;

   bcd_multi_digit_counter #(.DIGITS(DIGITS), .SATURATE(1'b0)) dut (
      .CLK(clk), .CLR(clr), .ENABLE(enable), .LOAD(load), .UP(up), .D(d),
      .Q(q_w), .CO(co_w), .TC(tc_w), .ERR(err_w)
   );

   bcd_multi_digit_counter #(.DIGITS(DIGITS), .SATURATE(1'b1)) dut_sat (
      .CLK(clk), .CLR(clr), .ENABLE(enable), .LOAD(load), .UP(up), .D(d),
      .Q(q_s), .CO(co_s), .TC(tc_s), .ERR(err_s)
   );

   function automatic logic [11:0] to_bcd(input int v);
      logic [11:0] r;
      int          t;
      t = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   function automatic bit bcd_ok(input logic [11:0] v);
      for (int i = 0; i < DIGITS; i++)
         if (v[4*i +: 4] > 4'd9) return 1'b0;
      return 1'b1;
   endfunction

   function automatic int from_bcd(input logic [11:0] v);
      int r;
      r = 0;
      for (int i = DIGITS - 1; i >= 0; i--)
         r = r * 10 + int'(v[4*i +: 4]);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         mv[k] = 0; mco[k] = 1'b0; merr[k] = 1'b0;
      end
   endfunction

   function automatic void model_step();
      for (int k = 0; k < 2; k++) begin
         if (!enable) begin
            mco[k] = 1'b0;
         end else if (load) begin
            mco[k] = 1'b0;
            if (bcd_ok(d)) begin
               mv[k] = from_bcd(d); merr[k] = 1'b0;
            end else begin
               merr[k] = 1'b1;
            end
         end else begin
            merr[k] = 1'b0;
            mco[k]  = 1'b0;
            if (up) begin
               if (mv[k] < MAXV)  mv[k] = mv[k] + 1;
               else if (k == 0)   begin mv[k] = 0; mco[k] = 1'b1; end
            end else begin
               if (mv[k] > 0)     mv[k] = mv[k] - 1;
               else if (k == 0)   begin mv[k] = MAXV; mco[k] = 1'b1; end
            end
         end
      end
   endfunction

   task automatic step(input bit en, input bit ld, input bit u, input logic [11:0] dv);
      exp_t e;
      enable = en; load = ld; up = u; d = dv;
      @(posedge clk);
      model_step();
      for (int k = 0; k < 2; k++) begin
         e.q[k] = mv[k]; e.co[k] = mco[k]; e.err[k] = merr[k];
      end
      exp_q.push_back(e);
      #1;
   endtask

   task automatic do_reset_mid();
      @(negedge clk);
      #1;
      clr = 1'b1;
      #1;
      model_reset();
      chk("async_clr_q",   q_w,   32'h0);
      chk("async_clr_co",  co_w,  32'h0);
      chk("async_clr_err", err_w, 32'h0);
      chk("async_clr_tc",  tc_w,  32'(!up));
      chk("async_clr_qs",  q_s,   32'h0);
      @(negedge clk);
      chk("clr_held_q", q_w, 32'h0);
      #1;
      clr = 1'b0;
   endtask

   // monitor: every cycle after an edge the DUT presents Q/CO/ERR; compare against the queue
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("q_wrap",   q_w,   32'(to_bcd(e.q[0])));
            chk("co_wrap",  co_w,  32'(e.co[0]));
            chk("err_wrap", err_w, 32'(e.err[0]));
            chk("tc_wrap",  tc_w,  32'(up ? (e.q[0] == MAXV) : (e.q[0] == 0)));
            chk("q_sat",    q_s,   32'(to_bcd(e.q[1])));
            chk("co_sat",   co_s,  32'(e.co[1]));
            chk("err_sat",  err_s, 32'(e.err[1]));
            chk("tc_sat",   tc_s,  32'(up ? (e.q[1] == MAXV) : (e.q[1] == 0)));
         end
      end
   end

   initial begin
      model_reset();
      #2;
      chk("rst_q",   q_w,   32'h0);
      chk("rst_co",  co_w,  32'h0);
      chk("rst_err", err_w, 32'h0);
      chk("rst_tc",  tc_w,  32'h1);
      @(negedge clk);
      #1;
      clr = 1'b0;

      // reset mid-count at 457
      step(1, 1, 1, 12'h456);
      step(1, 0, 1, 12'h000);
      up = 1'b0;
      do_reset_mid();

      // ripple up and wrap
      step(1, 1, 1, 12'h198);
      repeat (3) step(1, 0, 1, 12'h000);
      step(1, 1, 1, 12'h999);
      step(1, 0, 1, 12'h000);
      step(1, 0, 1, 12'h000);

      // ripple down and borrow
      step(1, 1, 0, 12'h100);
      repeat (2) step(1, 0, 0, 12'h000);
      step(1, 1, 0, 12'h000);
      step(1, 0, 0, 12'h000);
      step(1, 0, 0, 12'h000);

      // invalid load then recovery
      step(1, 1, 1, 12'h042);
      step(1, 1, 1, 12'h1A3);
      step(1, 1, 1, 12'h555);
      step(1, 1, 1, 12'hA00);
      step(1, 0, 1, 12'h000);

      // saturate vs wrap at the limit, then turn around
      step(1, 1, 1, 12'h999);
      repeat (4) step(1, 0, 1, 12'h000);
      step(1, 0, 0, 12'h000);
      step(1, 1, 0, 12'h000);
      repeat (2) step(1, 0, 0, 12'h000);

      // hold and priority
      step(1, 1, 1, 12'h777);
      step(0, 1, 1, 12'h321);
      step(0, 0, 1, 12'h000);
      step(1, 1, 1, 12'h321);

      // randomized traffic, biased toward the wrap boundaries
      for (int n = 0; n < 400; n++) begin
         int          r;
         logic [11:0] dv;
         r = int'($urandom_range(0, 99));
         if (r < 10)      dv = 12'($urandom_range(0, 4095));
         else if (r < 30) dv = ($urandom_range(0, 1) != 0) ? 12'h999 : 12'h000;
         else             dv = to_bcd(int'($urandom_range(0, MAXV)));
         step(($urandom_range(0, 9) != 0), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 2) != 0), dv);
      end

      repeat (2) @(negedge clk);
      #1;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
